// File: rtl/ls_buffer_pkg.sv
// Shared widths, opcode encodings and the queue-entry record for the load/store buffer.
package ls_buffer_pkg;
    localparam int DataBus = 32;
    localparam int TagBus  = 4;
    localparam int NameBus = 5;
    localparam int OpBus   = 6;

    localparam logic [TagBus-1:0]  tagFree  = '0;
    localparam logic [NameBus-1:0] nameFree = '0;
    localparam logic [DataBus-1:0] dataFree = '0;

    localparam logic [OpBus-1:0] LB  = 6'h20;
    localparam logic [OpBus-1:0] LH  = 6'h21;
    localparam logic [OpBus-1:0] LW  = 6'h23;
    localparam logic [OpBus-1:0] LBU = 6'h24;
    localparam logic [OpBus-1:0] LHU = 6'h25;
    localparam logic [OpBus-1:0] SB  = 6'h28;
    localparam logic [OpBus-1:0] SH  = 6'h29;
    localparam logic [OpBus-1:0] SW  = 6'h2B;

    localparam logic Enable  = 1'b1;
    localparam logic Disable = 1'b0;

    typedef struct packed {
        logic [OpBus-1:0]   op;
        logic [DataBus-1:0] data_o;
        logic [TagBus-1:0]  tag_o;
        logic [DataBus-1:0] data_t;
        logic [TagBus-1:0]  tag_t;
        logic [DataBus-1:0] imm;
        logic [TagBus-1:0]  wrt_tag;
        logic [NameBus-1:0] wrt_name;
    } ls_entry_t;

    function automatic logic is_store(input logic [OpBus-1:0] op);
        return (op == SB) || (op == SH) || (op == SW);
    endfunction

    // Resolve one operand against both broadcast buses; ALU takes precedence.
    function automatic logic [TagBus+DataBus-1:0] snoop(
        input logic [TagBus-1:0]  tag,
        input logic [DataBus-1:0] data,
        input logic               a_en,
        input logic [TagBus-1:0]  a_tag,
        input logic [DataBus-1:0] a_data,
        input logic               l_en,
        input logic [TagBus-1:0]  l_tag,
        input logic [DataBus-1:0] l_data
    );
        if (tag != tagFree && a_en && a_tag == tag) return {tagFree, a_data};
        if (tag != tagFree && l_en && l_tag == tag) return {tagFree, l_data};
        return {tag, data};
    endfunction
endpackage

// File: rtl/ls_buffer_entry.sv
// One queue slot: holds an op and keeps snooping both result buses until its operands resolve.
module ls_buffer_entry
    import ls_buffer_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               wr,
    input  logic               inv,
    input  ls_entry_t          din,
    input  logic               aluEn,
    input  logic [TagBus-1:0]  aluTag,
    input  logic [DataBus-1:0] aluData,
    input  logic               lsEn,
    input  logic [TagBus-1:0]  lsTag,
    input  logic [DataBus-1:0] lsData,
    output logic               valid,
    output ls_entry_t          q
);
    ls_entry_t base, nxt;

    // A push snoops the incoming operands so a same-cycle broadcast is not missed.
    always_comb begin
        base = wr ? din : q;
        nxt  = base;
        {nxt.tag_o, nxt.data_o} = snoop(base.tag_o, base.data_o, aluEn, aluTag, aluData,
                                        lsEn, lsTag, lsData);
        {nxt.tag_t, nxt.data_t} = snoop(base.tag_t, base.data_t, aluEn, aluTag, aluData,
                                        lsEn, lsTag, lsData);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= Disable;
            q     <= '0;
        end else begin
            q <= nxt;
            if (clear)    valid <= Disable;
            else if (wr)  valid <= Enable;
            else if (inv) valid <= Disable;
        end
    end
endmodule

// File: rtl/ls_buffer.sv
// In-order load/store queue: holds ops until operands resolve, issues only the head to LS.
module ls_buffer
    import ls_buffer_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               inEn,
    input  logic [OpBus-1:0]   inOp,
    input  logic [DataBus-1:0] inDataO,
    input  logic [TagBus-1:0]  inTagO,
    input  logic [DataBus-1:0] inDataT,
    input  logic [TagBus-1:0]  inTagT,
    input  logic [DataBus-1:0] inImm,
    input  logic [TagBus-1:0]  inWrtTag,
    input  logic [NameBus-1:0] inWrtName,
    output logic               full,
    input  logic               aluEn,
    input  logic [TagBus-1:0]  aluTag,
    input  logic [DataBus-1:0] aluData,
    input  logic               lsEn,
    input  logic [TagBus-1:0]  lsTag,
    input  logic [DataBus-1:0] lsData,
    input  logic [TagBus-1:0]  robHeadTag,
    input  logic               LSunwork,
    output logic               LSworkEn,
    output logic [DataBus-1:0] operandO,
    output logic [DataBus-1:0] operandT,
    output logic [DataBus-1:0] imm,
    output logic [TagBus-1:0]  wrtTag,
    output logic [NameBus-1:0] wrtName,
    output logic [OpBus-1:0]   opCode
);
    logic [PTR_W-1:0] head, tail;
    logic [PTR_W:0]   count;
    logic [DEPTH-1:0] valid;
    ls_entry_t        ent [DEPTH];
    ls_entry_t        din, hd;
    logic             push, issue, ready;

    assign full = (count == (PTR_W+1)'(DEPTH));
    assign push = inEn && !full && !flush;

    assign din = '{op: inOp, data_o: inDataO, tag_o: inTagO, data_t: inDataT, tag_t: inTagT,
                   imm: inImm, wrt_tag: inWrtTag, wrt_name: inWrtName};

    // Readiness looks only at registered slot state, so a broadcast helps one cycle later.
    assign hd    = ent[head];
    assign ready = valid[head] && hd.tag_o == tagFree &&
                   (!is_store(hd.op) || (hd.tag_t == tagFree && hd.wrt_tag == robHeadTag));
    assign issue = ready && LSunwork && !LSworkEn && !flush;

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        ls_buffer_entry u_entry (
            .clk     (clk),
            .rst     (rst),
            .clear   (flush),
            .wr      (push && tail == PTR_W'(i)),
            .inv     (issue && head == PTR_W'(i)),
            .din     (din),
            .aluEn   (aluEn),
            .aluTag  (aluTag),
            .aluData (aluData),
            .lsEn    (lsEn),
            .lsTag   (lsTag),
            .lsData  (lsData),
            .valid   (valid[i]),
            .q       (ent[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push)  tail <= tail + 1'b1;
            if (issue) head <= head + 1'b1;
            count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, issue};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            LSworkEn <= Disable;
            operandO <= dataFree;
            operandT <= dataFree;
            imm      <= dataFree;
            wrtTag   <= tagFree;
            wrtName  <= nameFree;
            opCode   <= '0;
        end else begin
            LSworkEn <= issue;
            if (issue) begin
                operandO <= hd.data_o;
                operandT <= hd.data_t;
                imm      <= hd.imm;
                wrtTag   <= hd.wrt_tag;
                wrtName  <= hd.wrt_name;
                opCode   <= hd.op;
            end
        end
    end
endmodule
